// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised pseudo-dual-port SRAM.
// byte_merge works on a wide container word; callers cast in and truncate out.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper supports; DATA_W must not exceed it.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_MASK_W = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_MASK_W-1:0] mask
    );
        logic [MAX_DATA_W-1:0] merged;
        for (int i = 0; i < MAX_MASK_W; i++) begin
            merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_pdp_core.sv
// Storage array: byte-masked synchronous write, combinational read mux.
// No reset; the caller guarantees addresses are in range before enabling a write.
module sram_pdp_core #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rd_word
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[raddr];

endmodule

// File: rtl/sram_pdp_param.sv
// Pseudo-dual-port SRAM top: post-reset clear sequencer, range checks,
// read-during-write selection and a 1- or 2-stage read output pipeline.
module sram_pdp_param
    import sram_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  web,
    input  logic [ADDR_W-1:0]     wadr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic                  reb,
    input  logic [ADDR_W-1:0]     radr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  init_busy,
    output logic                  addr_err
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

    clr_state_e          state_q, state_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;

    logic                ready, wr_in, rd_in, wr_fire, rd_fire;
    logic                core_we;
    logic [ADDR_W-1:0]   core_waddr;
    logic [DATA_W-1:0]   core_wdata, core_rd, rd_word;
    logic [DATA_W/8-1:0] core_wmask;
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= (CLR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST_X) state_d = READY;
                else                     clr_cnt_d = clr_cnt_q + 1'b1;
            end
            READY:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    assign init_busy = (state_q == CLEAR);
    assign ready     = (state_q == READY);
    assign wr_in     = ({1'b0, wadr} < DEPTH_X);
    assign rd_in     = ({1'b0, radr} < DEPTH_X);
    assign wr_fire   = ready & ~web;
    assign rd_fire   = ready & ~reb;

    // During CLEAR the sequencer owns the write port; user requests are ignored.
    assign core_we    = init_busy | (wr_fire & wr_in);
    assign core_waddr = init_busy ? clr_cnt_q[ADDR_W-1:0] : wadr;
    assign core_wdata = init_busy ? '0 : wdata;
    assign core_wmask = init_busy ? '1 : wmask;

    sram_pdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .we      (core_we),
        .waddr   (core_waddr),
        .wdata   (core_wdata),
        .wmask   (core_wmask),
        .raddr   (radr),
        .rd_word (core_rd)
    );

    // Out-of-range reads return zero; same-address collisions may forward the merged word.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = core_rd;
            if (RDW_MODE == RDW_NEW && wr_fire && wr_in && wadr == radr) begin
                rd_word = DATA_W'(byte_merge(MAX_DATA_W'(core_rd), MAX_DATA_W'(wdata),
                                             MAX_MASK_W'(wmask)));
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) s1_data <= rd_word;
            addr_err <= (wr_fire & ~wr_in) | (rd_fire & ~rd_in);
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end
            assign rvalid = s2_valid;
            assign rdata  = s2_data;
        end else begin : g_lat1
            assign rvalid = s1_valid;
            assign rdata  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_sram_pdp_param.sv
// Self-checking bench: two configurations of the SRAM share one stimulus stream
// and are compared against a word-array reference model with a delivery schedule.
module tb_sram_pdp_param;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int MW = DW / 8;
    localparam int DEP  [2] = '{256, 200};
    localparam int LAT  [2] = '{1, 2};
    localparam int RDWM [2] = '{0, 1};

    logic          clk = 1'b0;
    logic          rstb;
    logic          web;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          reb;
    logic [AW-1:0] radr;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, busy_a, busy_b, err_a, err_b;

    int n_checks = 0;
    int n_pass   = 0;

    sram_pdp_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RESET(1)
    ) u_a (
        .clk(clk), .rstb(rstb), .web(web), .wadr(wadr), .wdata(wdata), .wmask(wmask),
        .reb(reb), .radr(radr), .rdata(rdata_a), .rvalid(rvalid_a),
        .init_busy(busy_a), .addr_err(err_a)
    );

    sram_pdp_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RESET(0)
    ) u_b (
        .clk(clk), .rstb(rstb), .web(web), .wadr(wadr), .wdata(wdata), .wmask(wmask),
        .reb(reb), .radr(radr), .rdata(rdata_b), .rvalid(rvalid_b),
        .init_busy(busy_b), .addr_err(err_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem  [2][256];
    logic          sched_v  [2][4];
    logic [DW-1:0] sched_d  [2][4];
    logic          exp_valid[2];
    logic [DW-1:0] exp_data [2];
    logic          exp_err  [2];
    int            a_clear_left;
    int            cyc = 0;

    function automatic logic [DW-1:0] merged(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int b = 0; b < MW; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 4; s++) sched_v[k][s] = 1'b0;
            exp_valid[k] = 1'b0;
            exp_data[k]  = '0;
            exp_err[k]   = 1'b0;
        end
        a_clear_left = 256;
    endtask

    task automatic model_edge();
        bit            a_ready, ready, err;
        logic [DW-1:0] rd;
        int            slot;
        if (!rstb) return;
        a_ready = (a_clear_left == 0);
        for (int k = 0; k < 2; k++) begin
            ready = (k == 0) ? a_ready : 1'b1;
            err   = 1'b0;
            if (ready && !reb) begin
                if (int'(radr) >= DEP[k]) begin
                    rd  = '0;
                    err = 1'b1;
                end else if (RDWM[k] == 1 && !web && wadr == radr) begin
                    rd = merged(ref_mem[k][radr], wdata, wmask);
                end else begin
                    rd = ref_mem[k][radr];
                end
                slot = (cyc + LAT[k] - 1) % 4;
                sched_v[k][slot] = 1'b1;
                sched_d[k][slot] = rd;
            end
            if (ready && !web) begin
                if (int'(wadr) >= DEP[k]) err = 1'b1;
                else ref_mem[k][wadr] = merged(ref_mem[k][wadr], wdata, wmask);
            end
            exp_err[k] = err;
            slot = cyc % 4;
            exp_valid[k] = sched_v[k][slot];
            if (sched_v[k][slot]) begin
                exp_data[k]      = sched_d[k][slot];
                sched_v[k][slot] = 1'b0;
            end
        end
        if (!a_ready) begin
            a_clear_left--;
            if (a_clear_left == 0) for (int i = 0; i < 256; i++) ref_mem[0][i] = '0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        web = 1'b1;
        reb = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rstb = 1'b0;
        idle();
        wadr = '0; radr = '0; wdata = '0; wmask = '0;
        model_reset();
        repeat (3) tick();
        n_checks++; if (rdata_a !== 64'h0) $display("FAIL reset_rdata_a got %h want 0", rdata_a); else n_pass++;
        n_checks++; if (rvalid_a !== 1'b0) $display("FAIL reset_rvalid_a got %b want 0", rvalid_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL reset_busy_a got %b want 1", busy_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL reset_err_a got %b want 0", err_a); else n_pass++;
        n_checks++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b got %b want 0", busy_b); else n_pass++;
        n_checks++; if (rvalid_b !== 1'b0) $display("FAIL reset_rvalid_b got %b want 0", rvalid_b); else n_pass++;
        n_checks++; if (rdata_b !== 64'h0) $display("FAIL reset_rdata_b got %h want 0", rdata_b); else n_pass++;
        rstb = 1'b1;
        n = 0;
        // While A clears, fill every word of B so later reads of B are defined.
        while (busy_a === 1'b1 && n < 400) begin
            web   = (n < 200) ? 1'b0 : 1'b1;
            wadr  = n[AW-1:0];
            wdata = {$urandom, $urandom};
            wmask = '1;
            reb   = 1'b0;
            radr  = '0;
            tick();
            n++;
            n_checks++; if (rvalid_a !== 1'b0) $display("FAIL clear_rvalid_a got %b want 0 at n=%0d", rvalid_a, n); else n_pass++;
        end
        n_checks++; if (n != 256) $display("FAIL clear_cycles got %0d want 256", n); else n_pass++;
        web = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reb  = 1'b0;
            radr = (i == 0) ? 8'h00 : (i == 1) ? 8'h7F : 8'hFF;
            tick();
            n_checks++; if (rvalid_a !== 1'b1) $display("FAIL clear_read_valid got %b want 1 adr %h", rvalid_a, radr); else n_pass++;
            n_checks++; if (rdata_a !== 64'h0) $display("FAIL clear_read_data got %h want 0 adr %h", rdata_a, radr); else n_pass++;
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_masked_write();
        web = 1'b0; reb = 1'b1; wadr = 8'h10;
        wdata = 64'h1111_2222_3333_4444; wmask = 8'hFF;
        tick();
        wdata = 64'hAAAA_BBBB_CCCC_DDDD; wmask = 8'h0F;
        tick();
        web = 1'b1; reb = 1'b0; radr = 8'h10;
        tick();
        reb = 1'b1;
        n_checks++; if (rvalid_a !== 1'b1) $display("FAIL mask_rvalid_a got %b want 1", rvalid_a); else n_pass++;
        n_checks++; if (rdata_a !== 64'h1111_2222_CCCC_DDDD) $display("FAIL mask_rdata_a got %h want 1111_2222_cccc_dddd", rdata_a); else n_pass++;
        tick();
        n_checks++; if (rvalid_b !== 1'b1) $display("FAIL mask_rvalid_b got %b want 1", rvalid_b); else n_pass++;
        n_checks++; if (rdata_b !== 64'h1111_2222_CCCC_DDDD) $display("FAIL mask_rdata_b got %h want 1111_2222_cccc_dddd", rdata_b); else n_pass++;
        n_checks++; if (rvalid_a !== 1'b0) $display("FAIL mask_pulse_a got %b want 0", rvalid_a); else n_pass++;
        n_checks++; if (rdata_a !== 64'h1111_2222_CCCC_DDDD) $display("FAIL mask_hold_a got %h want 1111_2222_cccc_dddd", rdata_a); else n_pass++;
        tick();
    endtask

    task automatic test_latency();
        logic [DW-1:0] vals [3];
        vals[0] = 64'h1111_2222_CCCC_DDDD;
        vals[1] = 64'h0123_4567_89AB_CDEF;
        vals[2] = 64'hFEDC_BA98_7654_3210;
        web = 1'b0; reb = 1'b1; wmask = 8'hFF;
        wadr = 8'h11; wdata = vals[1]; tick();
        wadr = 8'h12; wdata = vals[2]; tick();
        web = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t < 3) begin
                reb  = 1'b0;
                radr = 8'h10 + 8'(t);
            end else begin
                reb = 1'b1;
            end
            tick();
            // A delivers at sample t for request t; B one sample later.
            n_checks++; if (rvalid_a !== (t < 3)) $display("FAIL lat1_valid t=%0d got %b want %b", t, rvalid_a, (t < 3)); else n_pass++;
            if (t < 3) begin
                n_checks++; if (rdata_a !== vals[t]) $display("FAIL lat1_data t=%0d got %h want %h", t, rdata_a, vals[t]); else n_pass++;
            end
            n_checks++; if (rvalid_b !== (t > 0)) $display("FAIL lat2_valid t=%0d got %b want %b", t, rvalid_b, (t > 0)); else n_pass++;
            if (t > 0) begin
                n_checks++; if (rdata_b !== vals[t-1]) $display("FAIL lat2_data t=%0d got %h want %h", t, rdata_b, vals[t-1]); else n_pass++;
            end
        end
        tick();
    endtask

    task automatic test_rdw();
        web = 1'b0; reb = 1'b1; wadr = 8'h20; wdata = '0; wmask = 8'hFF;
        tick();
        wdata = '1; reb = 1'b0; radr = 8'h20;
        tick();
        idle();
        n_checks++; if (rdata_a !== 64'h0) $display("FAIL rdw_old_a got %h want 0", rdata_a); else n_pass++;
        tick();
        n_checks++; if (rvalid_b !== 1'b1) $display("FAIL rdw_valid_b got %b want 1", rvalid_b); else n_pass++;
        n_checks++; if (rdata_b !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rdw_new_b got %h want ffffffffffffffff", rdata_b); else n_pass++;
        reb = 1'b0; radr = 8'h20;
        tick();
        reb = 1'b1;
        n_checks++; if (rdata_a !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rdw_after_a got %h want ffffffffffffffff", rdata_a); else n_pass++;
        tick();
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] wval;
        wval = {$urandom, $urandom};
        web = 1'b0; reb = 1'b1; wadr = 8'hC8; wdata = wval; wmask = 8'hFF;
        tick();
        web = 1'b1;
        n_checks++; if (err_b !== 1'b1) $display("FAIL oor_wr_err_b got %b want 1", err_b); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL oor_wr_err_a got %b want 0", err_a); else n_pass++;
        tick();
        n_checks++; if (err_b !== 1'b0) $display("FAIL oor_wr_pulse_b got %b want 0", err_b); else n_pass++;
        reb = 1'b0; radr = 8'hC8;
        tick();
        reb = 1'b1;
        n_checks++; if (err_b !== 1'b1) $display("FAIL oor_rd_err_b got %b want 1", err_b); else n_pass++;
        n_checks++; if (rdata_a !== wval) $display("FAIL oor_rd_a got %h want %h", rdata_a, wval); else n_pass++;
        tick();
        n_checks++; if (rvalid_b !== 1'b1) $display("FAIL oor_rvalid_b got %b want 1", rvalid_b); else n_pass++;
        n_checks++; if (rdata_b !== 64'h0) $display("FAIL oor_rdata_b got %h want 0", rdata_b); else n_pass++;
        n_checks++; if (err_b !== 1'b0) $display("FAIL oor_rd_pulse_b got %b want 0", err_b); else n_pass++;
        web = 1'b0; wadr = 8'hFF; reb = 1'b0; radr = 8'hFE;
        tick();
        idle();
        n_checks++; if (err_b !== 1'b1) $display("FAIL oor_both_err_b got %b want 1", err_b); else n_pass++;
        tick();
        n_checks++; if (err_b !== 1'b0) $display("FAIL oor_both_pulse_b got %b want 0", err_b); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            web   = 1'($urandom_range(0, 1));
            reb   = 1'($urandom_range(0, 1));
            wadr  = 8'($urandom_range(0, 255));
            wdata = {$urandom, $urandom};
            wmask = 8'($urandom);
            radr  = ($urandom_range(0, 3) == 0) ? wadr : 8'($urandom_range(0, 255));
            tick();
            n_checks++; if (rvalid_a !== exp_valid[0]) $display("FAIL rnd_rvalid_a i=%0d got %b want %b", i, rvalid_a, exp_valid[0]); else n_pass++;
            n_checks++; if (rdata_a !== exp_data[0]) $display("FAIL rnd_rdata_a i=%0d got %h want %h", i, rdata_a, exp_data[0]); else n_pass++;
            n_checks++; if (err_a !== exp_err[0]) $display("FAIL rnd_err_a i=%0d got %b want %b", i, err_a, exp_err[0]); else n_pass++;
            n_checks++; if (busy_a !== (a_clear_left > 0)) $display("FAIL rnd_busy_a i=%0d got %b", i, busy_a); else n_pass++;
            n_checks++; if (rvalid_b !== exp_valid[1]) $display("FAIL rnd_rvalid_b i=%0d got %b want %b", i, rvalid_b, exp_valid[1]); else n_pass++;
            n_checks++; if (rdata_b !== exp_data[1]) $display("FAIL rnd_rdata_b i=%0d got %h want %h", i, rdata_b, exp_data[1]); else n_pass++;
            n_checks++; if (err_b !== exp_err[1]) $display("FAIL rnd_err_b i=%0d got %b want %b", i, err_b, exp_err[1]); else n_pass++;
            n_checks++; if (busy_b !== 1'b0) $display("FAIL rnd_busy_b i=%0d got %b want 0", i, busy_b); else n_pass++;
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle();
        rstb = 1'b0;
        model_reset();
        tick();
        rstb = 1'b1;
        repeat (100) tick();
        rstb = 1'b0;
        model_reset();
        #1;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL midclr_busy_a got %b want 1", busy_a); else n_pass++;
        n_checks++; if (rdata_a !== 64'h0) $display("FAIL midclr_rdata_a got %h want 0", rdata_a); else n_pass++;
        repeat (2) tick();
        rstb = 1'b1;
        n = 0;
        while (busy_a === 1'b1 && n < 400) begin
            reb  = 1'b0;
            radr = 8'($urandom_range(0, 255));
            tick();
            n++;
            n_checks++; if (rvalid_a !== 1'b0) $display("FAIL midclr_rvalid_a got %b want 0 at n=%0d", rvalid_a, n); else n_pass++;
        end
        n_checks++; if (n != 256) $display("FAIL midclr_cycles got %0d want 256", n); else n_pass++;
        reb = 1'b0; radr = 8'h10;
        tick();
        idle();
        n_checks++; if (rvalid_a !== 1'b1) $display("FAIL midclr_read_valid got %b want 1", rvalid_a); else n_pass++;
        n_checks++; if (rdata_a !== 64'h0) $display("FAIL midclr_read_data got %h want 0", rdata_a); else n_pass++;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_latency();
        test_rdw();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
